// File: rtl/ast_mx.sv
// Avalon-ST packet multiplexer: RX_DIR input streams merged onto one output
// with packet-atomic round-robin arbitration and a single registered output stage.
module ast_mx #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 8,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int RX_DIR        = 4,
  parameter int SRC_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [RX_DIR*DATA_WIDTH-1:0]      ast_data_i,
  input  logic [RX_DIR-1:0]                 ast_startofpacket_i,
  input  logic [RX_DIR-1:0]                 ast_endofpacket_i,
  input  logic [RX_DIR-1:0]                 ast_valid_i,
  input  logic [RX_DIR*EMPTY_WIDTH-1:0]     ast_empty_i,
  input  logic [RX_DIR*CHANNEL_WIDTH-1:0]   ast_channel_i,
  output logic [RX_DIR-1:0]                 ast_ready_o,
  output logic [DATA_WIDTH-1:0]             ast_data_o,
  output logic                              ast_startofpacket_o,
  output logic                              ast_endofpacket_o,
  output logic                              ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]            ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]          ast_channel_o,
  output logic [SRC_SEL_WIDTH-1:0]          src_o,
  input  logic                              ast_ready_i
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  localparam logic [SRC_SEL_WIDTH:0]   LP_N    = (SRC_SEL_WIDTH+1)'(RX_DIR);
  localparam logic [SRC_SEL_WIDTH-1:0] LP_LAST = SRC_SEL_WIDTH'(RX_DIR - 1);

  state_t                     r_state, w_state_nxt;
  logic [SRC_SEL_WIDTH-1:0]   r_ptr, w_ptr_nxt;
  logic [SRC_SEL_WIDTH-1:0]   r_gnt, w_gnt_nxt, w_gnt;
  logic [SRC_SEL_WIDTH:0]     w_idx;
  logic                       w_req, w_adv, w_acc;
  logic [DATA_WIDTH-1:0]      w_sel_data;
  logic                       w_sel_sop, w_sel_eop;
  logic [EMPTY_WIDTH-1:0]     w_sel_empty;
  logic [CHANNEL_WIDTH-1:0]   w_sel_channel;

  // Grant: locked port while mid-packet, else first valid port from ptr, wrapping at RX_DIR.
  always_comb begin
    w_adv = !ast_valid_o || ast_ready_i;
    w_idx = '0;
    w_gnt = r_gnt;
    w_req = 1'b0;
    if (r_state == ST_LOCK) begin
      w_req = 1'b1;
    end else begin
      for (int unsigned i = 0; i < RX_DIR; i++) begin
        w_idx = {1'b0, r_ptr} + (SRC_SEL_WIDTH+1)'(i);
        if (w_idx >= LP_N) w_idx = w_idx - LP_N;
        if (!w_req && ast_valid_i[w_idx[SRC_SEL_WIDTH-1:0]]) begin
          w_req = 1'b1;
          w_gnt = w_idx[SRC_SEL_WIDTH-1:0];
        end
      end
    end
    w_acc = rst_n_i && w_adv && w_req && ast_valid_i[w_gnt];
  end

  always_comb begin
    ast_ready_o = '0;
    for (int unsigned k = 0; k < RX_DIR; k++) begin
      ast_ready_o[k] = rst_n_i && w_adv && w_req && (w_gnt == SRC_SEL_WIDTH'(k));
    end
  end

  always_comb begin
    w_sel_data    = ast_data_i[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
    w_sel_sop     = ast_startofpacket_i[w_gnt];
    w_sel_eop     = ast_endofpacket_i[w_gnt];
    w_sel_empty   = ast_empty_i[int'(w_gnt)*EMPTY_WIDTH +: EMPTY_WIDTH];
    w_sel_channel = ast_channel_i[int'(w_gnt)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    if (w_acc) begin
      w_gnt_nxt = w_gnt;
      if (w_sel_eop) begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = (w_gnt == LP_LAST) ? '0 : w_gnt + SRC_SEL_WIDTH'(1);
      end else begin
        w_state_nxt = ST_LOCK;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ast_valid_o         <= 1'b0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_data_o          <= '0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
      src_o               <= '0;
    end else if (w_adv) begin
      ast_valid_o <= w_acc;
      if (w_acc) begin
        ast_data_o          <= w_sel_data;
        ast_startofpacket_o <= w_sel_sop;
        ast_endofpacket_o   <= w_sel_eop;
        ast_empty_o         <= w_sel_empty;
        ast_channel_o       <= w_sel_channel;
        src_o               <= w_gnt;
      end
    end
  end

endmodule

// File: tb/tb_ast_mx.sv
// Directed self-checking bench for ast_mx: 4-port default build plus a 3-port build.
module tb_ast_mx;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int EW = 3;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*DW-1:0] data_i;
  logic [N-1:0]    sop_i, eop_i, vld_i, rdy_o;
  logic [N*EW-1:0] emp_i;
  logic [N*CW-1:0] ch_i;
  logic [DW-1:0]   data_o;
  logic            sop_o, eop_o, vld_o, rdy_i;
  logic [EW-1:0]   emp_o;
  logic [CW-1:0]   ch_o;
  logic [1:0]      src_o;

  logic [3*DW-1:0] data3_i;
  logic [2:0]      sop3_i, eop3_i, vld3_i, rdy3_o;
  logic [3*EW-1:0] emp3_i;
  logic [3*CW-1:0] ch3_i;
  logic [DW-1:0]   data3_o;
  logic            sop3_o, eop3_o, vld3_o, rdy3_i;
  logic [EW-1:0]   emp3_o;
  logic [CW-1:0]   ch3_o;
  logic [1:0]      src3_o;

  ast_mx #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .RX_DIR(N)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ast_data_i(data_i), .ast_startofpacket_i(sop_i), .ast_endofpacket_i(eop_i),
    .ast_valid_i(vld_i), .ast_empty_i(emp_i), .ast_channel_i(ch_i), .ast_ready_o(rdy_o),
    .ast_data_o(data_o), .ast_startofpacket_o(sop_o), .ast_endofpacket_o(eop_o),
    .ast_valid_o(vld_o), .ast_empty_o(emp_o), .ast_channel_o(ch_o), .src_o(src_o),
    .ast_ready_i(rdy_i)
  );

  ast_mx #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .RX_DIR(3)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .ast_data_i(data3_i), .ast_startofpacket_i(sop3_i), .ast_endofpacket_i(eop3_i),
    .ast_valid_i(vld3_i), .ast_empty_i(emp3_i), .ast_channel_i(ch3_i), .ast_ready_o(rdy3_o),
    .ast_data_o(data3_o), .ast_startofpacket_o(sop3_o), .ast_endofpacket_o(eop3_o),
    .ast_valid_o(vld3_o), .ast_empty_o(emp3_o), .ast_channel_o(ch3_o), .src_o(src3_o),
    .ast_ready_i(rdy3_i)
  );

  int total = 0;
  int bad   = 0;
  int cnt[N];
  int len[N];
  int ord[12] = '{3, 3, 3, 0, 0, 0, 1, 1, 1, 2, 2, 2};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Port k presents beat cnt[k] of a len[k]-beat packet; data = {port, beat}.
  task automatic drive_ports();
    for (int k = 0; k < N; k++) begin
      vld_i[k] = (cnt[k] < len[k]);
      sop_i[k] = (cnt[k] == 0);
      eop_i[k] = (cnt[k] == len[k] - 1);
      data_i[k*DW +: DW] = {32'(k), 32'(cnt[k])};
      emp_i[k*EW +: EW]  = 3'(k);
      ch_i[k*CW +: CW]   = 8'h10 + 8'(k);
    end
  endtask

  task automatic run_cycle(input logic rdy, input logic [N-1:0] exp_rdy, input logic exp_vld,
                           input int es, input int eb, input string tag);
    logic [N-1:0] acc;
    drive_ports();
    rdy_i = rdy;
    #1;
    chk({tag, ".ready"}, 64'(rdy_o), 64'(exp_rdy));
    acc = exp_rdy & vld_i;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (acc[k]) cnt[k]++;
    chk({tag, ".valid"}, 64'(vld_o), 64'(exp_vld));
    if (exp_vld) begin
      chk({tag, ".src"},  64'(src_o), 64'(es));
      chk({tag, ".data"}, data_o, {32'(es), 32'(eb)});
      chk({tag, ".sop"},  64'(sop_o), 64'(eb == 0));
      chk({tag, ".eop"},  64'(eop_o), 64'(eb == len[es] - 1));
      chk({tag, ".empty"}, 64'(emp_o), 64'(es));
      chk({tag, ".chan"}, 64'(ch_o), 64'(8'h10 + 8'(es)));
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy_i = 1'b0; rdy3_i = 1'b0;
    data_i = '0; sop_i = '0; eop_i = '0; vld_i = '0; emp_i = '0; ch_i = '0;
    data3_i = '0; sop3_i = '0; eop3_i = '0; vld3_i = '0; emp3_i = '0; ch3_i = '0;
    for (int k = 0; k < N; k++) begin cnt[k] = 0; len[k] = 0; end

    // reset state, ready held low even with a valid input
    vld_i[0] = 1'b1;
    rdy_i = 1'b1;
    #12;
    chk("rst.ready", 64'(rdy_o), 64'd0);
    chk("rst.valid", 64'(vld_o), 64'd0);
    chk("rst.data", data_o, 64'd0);
    chk("rst.src", 64'(src_o), 64'd0);
    chk("rst.sop_eop", 64'({sop_o, eop_o}), 64'd0);
    vld_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single-beat packet on port 2
    data_i[2*DW +: DW] = 64'hDEAD_BEEF;
    sop_i[2] = 1'b1; eop_i[2] = 1'b1; vld_i[2] = 1'b1;
    emp_i[2*EW +: EW] = 3'd3; ch_i[2*CW +: CW] = 8'h5A;
    #1;
    chk("single.ready", 64'(rdy_o), 64'b0100);
    @(posedge clk); #1;
    vld_i = '0; sop_i = '0; eop_i = '0;
    chk("single.valid", 64'(vld_o), 64'd1);
    chk("single.data", data_o, 64'hDEAD_BEEF);
    chk("single.sop_eop", 64'({sop_o, eop_o}), 64'b11);
    chk("single.empty", 64'(emp_o), 64'd3);
    chk("single.chan", 64'(ch_o), 64'h5A);
    chk("single.src", 64'(src_o), 64'd2);
    @(posedge clk); #1;
    chk("single.drop", 64'(vld_o), 64'd0);
    chk("single.hold", data_o, 64'hDEAD_BEEF);

    // all ports with 3-beat packets; ptr is 3 after the port-2 packet
    for (int k = 0; k < N; k++) begin cnt[k] = 0; len[k] = 3; end
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 4'(1 << ord[i]), 1'b1, ord[i], i % 3, "rr");
    run_cycle(1'b1, 4'b0000, 1'b0, 0, 0, "rr_idle");

    // port 1 locked mid-packet while port 0 waits, with backpressure
    len[1] = 4; cnt[1] = 0;
    run_cycle(1'b1, 4'b0010, 1'b1, 1, 0, "lock0");
    len[0] = 1; cnt[0] = 0;
    run_cycle(1'b1, 4'b0010, 1'b1, 1, 1, "lock1");
    run_cycle(1'b0, 4'b0000, 1'b1, 1, 1, "stall0");
    run_cycle(1'b0, 4'b0000, 1'b1, 1, 1, "stall1");
    run_cycle(1'b1, 4'b0010, 1'b1, 1, 2, "lock2");
    run_cycle(1'b1, 4'b0010, 1'b1, 1, 3, "lock3");
    run_cycle(1'b1, 4'b0001, 1'b1, 0, 0, "switch");
    run_cycle(1'b1, 4'b0000, 1'b0, 0, 0, "lock_idle");

    // reset mid-packet on port 1; port 3 must be served cleanly afterwards
    len[1] = 8; cnt[1] = 0;
    run_cycle(1'b1, 4'b0010, 1'b1, 1, 0, "pre_rst0");
    run_cycle(1'b1, 4'b0010, 1'b1, 1, 1, "pre_rst1");
    run_cycle(1'b1, 4'b0010, 1'b1, 1, 2, "pre_rst2");
    len[3] = 2; cnt[3] = 0;
    drive_ports();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.ready", 64'(rdy_o), 64'd0);
    chk("mrst.valid", 64'(vld_o), 64'd0);
    chk("mrst.data", data_o, 64'd0);
    chk("mrst.src", 64'(src_o), 64'd0);
    chk("mrst.fields", 64'({sop_o, eop_o, emp_o, ch_o}), 64'd0);
    cnt[1] = len[1];
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle(1'b1, 4'b1000, 1'b1, 3, 0, "post_rst0");
    run_cycle(1'b1, 4'b1000, 1'b1, 3, 1, "post_rst1");
    len[0] = 1; cnt[0] = 0; len[2] = 1; cnt[2] = 0;
    run_cycle(1'b1, 4'b0001, 1'b1, 0, 0, "wrap4_0");
    run_cycle(1'b1, 4'b0100, 1'b1, 2, 0, "wrap4_2");
    run_cycle(1'b1, 4'b0000, 1'b0, 0, 0, "post_idle");

    // 3-port build: EOP from port 2 wraps ptr to 0
    rdy3_i = 1'b1;
    data3_i[2*DW +: DW] = 64'h22;
    vld3_i = 3'b100; sop3_i = 3'b100; eop3_i = 3'b100;
    #1;
    chk("p3.ready2", 64'(rdy3_o), 64'b100);
    @(posedge clk); #1;
    chk("p3.src2", 64'(src3_o), 64'd2);
    chk("p3.data2", data3_o, 64'h22);
    chk("p3.fields2", 64'({vld3_o, sop3_o, eop3_o, emp3_o, ch3_o}), 64'({3'b111, 3'd0, 8'd0}));
    data3_i[0 +: DW] = 64'h10; data3_i[DW +: DW] = 64'h11;
    vld3_i = 3'b011; sop3_i = 3'b011; eop3_i = 3'b011;
    #1;
    chk("p3.ready0", 64'(rdy3_o), 64'b001);
    @(posedge clk); #1;
    chk("p3.src0", 64'(src3_o), 64'd0);
    chk("p3.data0", data3_o, 64'h10);
    vld3_i = 3'b010;
    #1;
    chk("p3.ready1", 64'(rdy3_o), 64'b010);
    @(posedge clk); #1;
    vld3_i = '0;
    chk("p3.src1", 64'(src3_o), 64'd1);
    chk("p3.data1", data3_o, 64'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
